// File: rtl/instr_loader_if.sv
// Loader/fetch bus: program byte stream in, processor fetch port and status out.
interface instr_loader_if;
  logic       LOAD_START;
  logic       LOAD_VALID;
  logic [7:0] LOAD_DATA;
  logic       LOAD_LAST;
  logic       LOAD_READY;
  logic [7:0] PC;
  logic [7:0] INSTR;
  logic       CPU_HOLD;
  logic [8:0] PROG_LEN;
  logic       END_OF_PROG;
  logic       OVF;

  modport slave (
    input  LOAD_START, LOAD_VALID, LOAD_DATA, LOAD_LAST, PC,
    output LOAD_READY, INSTR, CPU_HOLD, PROG_LEN, END_OF_PROG, OVF
  );

  modport master (
    output LOAD_START, LOAD_VALID, LOAD_DATA, LOAD_LAST, PC,
    input  LOAD_READY, INSTR, CPU_HOLD, PROG_LEN, END_OF_PROG, OVF
  );
endinterface

// File: rtl/instr_loader.sv
// Instruction memory that is filled from a byte stream and then serves
// INSTR combinationally for the processor's PC, holding the CPU while loading.
module instr_loader #(
  parameter int         DEPTH = 256,
  parameter logic [7:0] FILL  = 8'h00
) (
  input  logic           CLK,
  input  logic           RST,
  instr_loader_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  localparam logic [7:0] LAST_ADDR = 8'(DEPTH - 1);

  state_t     r_state, w_next;
  logic [7:0] r_mem [0:DEPTH-1];
  logic [7:0] r_wr_ptr;
  logic [8:0] r_prog_len;
  logic       r_ovf;
  logic       r_cpu_hold;

  logic w_ready, w_xfer, w_full, w_in_prog;

  assign w_ready   = (r_state == S_LOAD) && !bus.LOAD_START;
  assign w_xfer    = bus.LOAD_VALID && w_ready;
  assign w_full    = (r_wr_ptr == LAST_ADDR);
  assign w_in_prog = ({1'b0, bus.PC} < r_prog_len);

  always_ff @(posedge CLK) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.LOAD_START) w_next = S_LOAD;
      S_LOAD: if (w_xfer && (bus.LOAD_LAST || w_full)) w_next = S_RUN;
      S_RUN:  if (bus.LOAD_START) w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  // Any accepted LOAD_START begins a fresh program; in LOAD it also blocks
  // the write that cycle because w_ready is low.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_wr_ptr   <= 8'd0;
      r_prog_len <= 9'd0;
      r_ovf      <= 1'b0;
      r_cpu_hold <= 1'b1;
    end else begin
      r_cpu_hold <= (w_next != S_RUN);
      if (bus.LOAD_START) begin
        r_wr_ptr   <= 8'd0;
        r_prog_len <= 9'd0;
        r_ovf      <= 1'b0;
      end else if (w_xfer) begin
        r_wr_ptr   <= r_wr_ptr + 8'd1;
        r_prog_len <= {1'b0, r_wr_ptr} + 9'd1;
        if (w_full && !bus.LOAD_LAST) r_ovf <= 1'b1;
      end
    end
  end

  // Memory survives reset; only PROG_LEN decides what is visible.
  always_ff @(posedge CLK) begin
    if (RST && w_xfer) r_mem[r_wr_ptr] <= bus.LOAD_DATA;
  end

  assign bus.LOAD_READY  = w_ready;
  assign bus.CPU_HOLD    = r_cpu_hold;
  assign bus.PROG_LEN    = r_prog_len;
  assign bus.OVF         = r_ovf;
  assign bus.INSTR       = (r_state == S_RUN && w_in_prog) ? r_mem[bus.PC] : FILL;
  assign bus.END_OF_PROG = (r_state == S_RUN) && !w_in_prog;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: load, fetch, gaps, overflow, restart, reset.
module tb_instr_loader;
  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  instr_loader_if bus ();

  instr_loader #(.DEPTH(256), .FILL(8'h00)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic st, input logic v, input logic [7:0] d, input logic l);
    bus.LOAD_START = st;
    bus.LOAD_VALID = v;
    bus.LOAD_DATA  = d;
    bus.LOAD_LAST  = l;
    #1;
  endtask

  task automatic fetch(input string tag, input logic [7:0] pc,
                       input logic [7:0] exp_i, input logic exp_e);
    bus.PC = pc;
    #1;
    chk({tag, "_instr"}, 16'(bus.INSTR), 16'(exp_i));
    chk({tag, "_eop"}, 16'(bus.END_OF_PROG), 16'(exp_e));
  endtask

  initial begin
    RST = 1'b0;
    bus.PC = 8'h05;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick(); tick();
    chk("rst_hold",  16'(bus.CPU_HOLD), 16'd1);
    chk("rst_ready", 16'(bus.LOAD_READY), 16'd0);
    chk("rst_len",   16'(bus.PROG_LEN), 16'd0);
    chk("rst_ovf",   16'(bus.OVF), 16'd0);
    chk("rst_instr", 16'(bus.INSTR), 16'h00);
    chk("rst_eop",   16'(bus.END_OF_PROG), 16'd0);

    // Basic 3-byte load with VALID held
    RST = 1'b1;
    tick();
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    drive(1'b0, 1'b1, 8'h11, 1'b0);
    chk("ld_ready0", 16'(bus.LOAD_READY), 16'd1);
    chk("ld_hold0",  16'(bus.CPU_HOLD), 16'd1);
    tick();
    drive(1'b0, 1'b1, 8'h52, 1'b0);
    chk("ld_ready1", 16'(bus.LOAD_READY), 16'd1);
    chk("ld_len1",   16'(bus.PROG_LEN), 16'd1);
    tick();
    drive(1'b0, 1'b1, 8'hC1, 1'b1);
    chk("ld_ready2", 16'(bus.LOAD_READY), 16'd1);
    chk("ld_len2",   16'(bus.PROG_LEN), 16'd2);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("run_ready", 16'(bus.LOAD_READY), 16'd0);
    chk("run_len",   16'(bus.PROG_LEN), 16'd3);
    chk("run_hold",  16'(bus.CPU_HOLD), 16'd0);
    fetch("pc0", 8'd0, 8'h11, 1'b0);
    fetch("pc1", 8'd1, 8'h52, 1'b0);
    fetch("pc2", 8'd2, 8'hC1, 1'b0);
    fetch("pc3", 8'd3, 8'h00, 1'b1);

    // Gaps and LAST without VALID
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    drive(1'b0, 1'b1, 8'hA0, 1'b0);
    chk("gap_hold", 16'(bus.CPU_HOLD), 16'd1);
    chk("gap_len0", 16'(bus.PROG_LEN), 16'd0);
    fetch("gap_ld_instr", 8'd0, 8'h00, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'hFF, 1'b1);
    tick();
    drive(1'b0, 1'b0, 8'hFF, 1'b0);
    tick();
    drive(1'b0, 1'b1, 8'hA1, 1'b1);
    chk("gap_len1",  16'(bus.PROG_LEN), 16'd1);
    chk("gap_ready", 16'(bus.LOAD_READY), 16'd1);
    chk("gap_hold1", 16'(bus.CPU_HOLD), 16'd1);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("gap_len2", 16'(bus.PROG_LEN), 16'd2);
    chk("gap_run",  16'(bus.CPU_HOLD), 16'd0);
    fetch("gap_pc0", 8'd0, 8'hA0, 1'b0);
    fetch("gap_pc1", 8'd1, 8'hA1, 1'b0);
    fetch("gap_pc2", 8'd2, 8'h00, 1'b1);

    // 256 bytes without LAST: truncation at DEPTH
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 1'b1, 8'(i), 1'b0);
      if (i == 255) begin
        chk("ovf_pre_len",  16'(bus.PROG_LEN), 16'd255);
        chk("ovf_pre_hold", 16'(bus.CPU_HOLD), 16'd1);
        chk("ovf_pre_flag", 16'(bus.OVF), 16'd0);
      end
      tick();
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("ovf_flag", 16'(bus.OVF), 16'd1);
    chk("ovf_len",  16'(bus.PROG_LEN), 16'd256);
    chk("ovf_hold", 16'(bus.CPU_HOLD), 16'd0);
    fetch("ovf_pcFF", 8'hFF, 8'hFF, 1'b0);
    fetch("ovf_pc80", 8'h80, 8'h80, 1'b0);
    fetch("ovf_pc00", 8'h00, 8'h00, 1'b0);

    // Reload a 3-byte program, then restart from RUN with START+VALID
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    drive(1'b0, 1'b1, 8'h01, 1'b0); tick();
    drive(1'b0, 1'b1, 8'h02, 1'b0); tick();
    drive(1'b0, 1'b1, 8'h03, 1'b1); tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("r3_len", 16'(bus.PROG_LEN), 16'd3);
    fetch("r3_pc1", 8'd1, 8'h02, 1'b0);
    drive(1'b1, 1'b1, 8'hEE, 1'b0);
    chk("rs_ready_run", 16'(bus.LOAD_READY), 16'd0);
    tick();
    chk("rs_hold",  16'(bus.CPU_HOLD), 16'd1);
    chk("rs_len",   16'(bus.PROG_LEN), 16'd0);
    chk("rs_ready", 16'(bus.LOAD_READY), 16'd0);
    tick();
    drive(1'b0, 1'b1, 8'h7E, 1'b1);
    chk("rs_len_nowr", 16'(bus.PROG_LEN), 16'd0);
    chk("rs_ready1",   16'(bus.LOAD_READY), 16'd1);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("rs_len1", 16'(bus.PROG_LEN), 16'd1);
    chk("rs_hold1", 16'(bus.CPU_HOLD), 16'd0);
    fetch("rs_pc0", 8'd0, 8'h7E, 1'b0);
    fetch("rs_pc1", 8'd1, 8'h00, 1'b1);

    // Reset mid-load; simultaneous LOAD_START ignored
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    drive(1'b0, 1'b1, 8'h33, 1'b0); tick();
    drive(1'b0, 1'b1, 8'h44, 1'b0); tick();
    chk("mr_len2", 16'(bus.PROG_LEN), 16'd2);
    RST = 1'b0;
    drive(1'b1, 1'b1, 8'h55, 1'b0);
    tick();
    drive(1'b0, 1'b1, 8'h55, 1'b0);
    chk("mr_hold",  16'(bus.CPU_HOLD), 16'd1);
    chk("mr_len",   16'(bus.PROG_LEN), 16'd0);
    chk("mr_ready", 16'(bus.LOAD_READY), 16'd0);
    RST = 1'b1;
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("mr_idle_ready", 16'(bus.LOAD_READY), 16'd0);
    chk("mr_idle_hold",  16'(bus.CPU_HOLD), 16'd1);
    fetch("mr_pc0", 8'd0, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Instruction-side counterpart of the 8-bit microprocessor. The processor reads instructions by presenting PC and consuming INSTR; this block writes and serves those instructions.
- It accepts a program as a stream of bytes over a valid/ready handshake and stores it in an internal instruction memory.
- It then serves INSTR combinationally for the PC the processor presents.
- It holds the processor in reset while a program is loading and releases it when loading completes.

Parameters:
- DEPTH, 256, number of instruction words; the address is 8 bits wide, matching PC.
- FILL, 8'h00, value driven on INSTR for any address at or beyond the loaded program length.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  reset, synchronous, active-low.
- LOAD_START  in  1  one-cycle pulse that begins or restarts a program load.
- LOAD_VALID  in  1  LOAD_DATA holds a valid instruction byte.
- LOAD_DATA  in  8  instruction byte.
- LOAD_LAST  in  1  qualifies the current byte as the final byte of the program.
- LOAD_READY  out  1  loader accepts a byte this cycle.
- PC  in  8  fetch address from the processor.
- INSTR  out  8  instruction at PC.
- CPU_HOLD  out  1  high keeps the processor in reset.
- PROG_LEN  out  9  number of bytes loaded, 0..256.
- END_OF_PROG  out  1  PC >= PROG_LEN while in RUN.
- OVF  out  1  sticky flag: a load was truncated at DEPTH.

Behaviour:
- States: IDLE, LOAD, RUN; 2-bit state register.
- Reset (RST=0 at a clock edge):
  - state=IDLE, wr_ptr=0, PROG_LEN=0, OVF=0, CPU_HOLD=1.
  - Memory contents are not cleared. Because PROG_LEN=0, INSTR=FILL for every PC.
- IDLE:
  - LOAD_START=1 -> LOAD on the next edge; wr_ptr=0, PROG_LEN=0, OVF=0.
  - All other inputs are ignored.
- LOAD:
  - LOAD_READY = (state==LOAD) && !LOAD_START. This is combinational from the state register and LOAD_START.
  - A transfer occurs when LOAD_VALID && LOAD_READY. On a transfer: mem[wr_ptr]<=LOAD_DATA, wr_ptr<=wr_ptr+1, PROG_LEN<=wr_ptr+1.
  - If a transfer has LOAD_LAST=1 -> RUN on the next edge.
  - If a transfer occurs at wr_ptr==DEPTH-1 with LOAD_LAST=0: the byte is written, PROG_LEN=DEPTH, OVF<=1, -> RUN. The byte is treated as an implicit last byte.
  - LOAD_START=1 in LOAD restarts the load: wr_ptr=0, PROG_LEN=0, no write that cycle, state stays LOAD.
  - LOAD_VALID with no transfer has no effect. LOAD_LAST without LOAD_VALID is ignored.
- RUN:
  - CPU_HOLD=0 from the first cycle in RUN.
  - INSTR = (PC < PROG_LEN) ? mem[PC] : FILL. This is an asynchronous read with zero-cycle latency, so a single-cycle processor sees the instruction in the same cycle PC changes.
  - END_OF_PROG = (PC >= PROG_LEN), combinational, RUN only; 0 in other states.
  - LOAD_START=1 -> LOAD on the next edge, with CPU_HOLD=1 from that edge. The processor is therefore reset before any memory byte changes.
- CPU_HOLD is registered: 1 in IDLE and LOAD, 0 in RUN.
- INSTR = FILL in IDLE and LOAD, independent of PC.
- wr_ptr is 8 bits and PROG_LEN is 9 bits, so PROG_LEN reaches 256 without wrap. wr_ptr never wraps; the DEPTH rule ends the load first.
- Reset mid-load: the partial program is discarded (PROG_LEN=0), state=IDLE, CPU_HOLD=1.
- Reset has priority over LOAD_START.

Test Plan:
- Reset with RST=0 for 2 cycles -> CPU_HOLD=1, LOAD_READY=0, PROG_LEN=0, OVF=0; with PC=8'h05, INSTR=8'h00.
- Pulse LOAD_START, then stream 8'h11, 8'h52, 8'hC1 with LOAD_LAST on the third byte, VALID held continuously -> LOAD_READY=1 for 3 cycles, PROG_LEN=3, state RUN, CPU_HOLD=0.
  - Then PC=0/1/2/3 -> INSTR=11/52/C1/00 respectively, END_OF_PROG=1 only at PC=3.
- Backpressure/gaps: drop LOAD_VALID for 2 cycles between bytes; assert LOAD_LAST with VALID=0 -> no write, no state change, PROG_LEN unchanged.
- Stream 256 bytes with value=index and no LOAD_LAST -> OVF=1, PROG_LEN=256, RUN entered after byte 255; PC=8'hFF -> INSTR=8'hFF, END_OF_PROG=0.
- In RUN with a 3-byte program, pulse LOAD_START coincident with LOAD_VALID -> CPU_HOLD=1 next cycle, LOAD_READY=0 that cycle, no byte written.
  - Then load 1 byte 8'h7E with LAST -> PROG_LEN=1, PC=1 -> INSTR=8'h00.
- Assert RST=0 after 2 bytes of a load -> IDLE, PROG_LEN=0, CPU_HOLD=1; a simultaneous LOAD_START is ignored.
